// File: rtl/rvh_mmu_req_arbiter.sv
// N-channel TLB miss/flush front end for the shared L2 MMU: arbitrates misses,
// tracks response ownership in an in-order FIFO and serialises per-channel flushes.
module rvh_mmu_req_arbiter #(
    parameter int CH_COUNT       = 2,
    parameter int ARB_MODE       = 0,
    parameter int OUTSTANDING    = 2,
    parameter int TRANS_ID_WIDTH = 3,
    parameter int VPN_WIDTH      = 27,
    parameter int ASID_WIDTH     = 16,
    parameter int PAGE_LVL_WIDTH = 2
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [CH_COUNT-1:0]                ch_req_vld_i,
    input  logic [CH_COUNT*TRANS_ID_WIDTH-1:0] ch_req_trans_id_i,
    input  logic [CH_COUNT*ASID_WIDTH-1:0]     ch_req_asid_i,
    input  logic [CH_COUNT*VPN_WIDTH-1:0]      ch_req_vpn_i,
    input  logic [CH_COUNT*2-1:0]              ch_req_access_type_i,
    output logic [CH_COUNT-1:0]                ch_req_rdy_o,
    output logic [CH_COUNT-1:0]                ch_resp_vld_o,
    output logic                               mmu_req_vld_o,
    output logic [TRANS_ID_WIDTH-1:0]          mmu_req_trans_id_o,
    output logic [ASID_WIDTH-1:0]              mmu_req_asid_o,
    output logic [VPN_WIDTH-1:0]               mmu_req_vpn_o,
    output logic [1:0]                         mmu_req_access_type_o,
    input  logic                               mmu_req_rdy_i,
    input  logic                               mmu_resp_vld_i,
    input  logic [CH_COUNT-1:0]                ch_flush_vld_i,
    input  logic [CH_COUNT-1:0]                ch_flush_use_asid_i,
    input  logic [CH_COUNT-1:0]                ch_flush_use_vpn_i,
    input  logic [CH_COUNT*VPN_WIDTH-1:0]      ch_flush_vpn_i,
    input  logic [CH_COUNT*ASID_WIDTH-1:0]     ch_flush_asid_i,
    output logic [CH_COUNT-1:0]                ch_flush_grant_o,
    output logic                               mmu_flush_vld_o,
    output logic                               mmu_flush_use_asid_o,
    output logic                               mmu_flush_use_vpn_o,
    output logic [VPN_WIDTH-1:0]               mmu_flush_vpn_o,
    output logic [ASID_WIDTH-1:0]              mmu_flush_asid_o,
    input  logic                               mmu_flush_grant_i,
    output logic                               resp_orphan_o
);

    localparam int CH_ID_WIDTH = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;
    localparam int PTR_WIDTH   = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_WIDTH   = $clog2(OUTSTANDING + 1);
    localparam logic [CH_ID_WIDTH-1:0] LAST_CH   = CH_ID_WIDTH'(CH_COUNT - 1);
    localparam logic [PTR_WIDTH-1:0]   LAST_SLOT = PTR_WIDTH'(OUTSTANDING - 1);
    localparam logic [CNT_WIDTH-1:0]   FULL_CNT  = CNT_WIDTH'(OUTSTANDING);
    localparam logic [CH_COUNT-1:0]    ONE_HOT0  = CH_COUNT'(1);

    // Page-level information is carried on the response path, which bypasses this block.
    if (PAGE_LVL_WIDTH < 1) begin : g_page_lvl_unused
    end

    typedef enum logic {
        FL_IDLE,
        FL_ISSUE
    } fl_state_e;

    logic                   locked;
    logic [CH_ID_WIDTH-1:0] lock_idx;
    logic [CH_ID_WIDTH-1:0] rr_ptr;
    logic [CH_COUNT-1:0]    eligible;
    logic                   arb_found;
    logic [CH_ID_WIDTH-1:0] arb_idx;
    logic [CH_ID_WIDTH-1:0] winner;
    logic                   req_any;
    logic                   handshake;

    logic [CH_ID_WIDTH-1:0] owner_q [OUTSTANDING];
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [CNT_WIDTH-1:0]   count;
    logic                   fifo_full;
    logic                   pop;
    logic                   orphan;

    logic [CH_COUNT-1:0]    pending;
    logic [CH_COUNT-1:0]    capture;
    logic [CH_COUNT-1:0]    fl_clear;
    logic                   pend_any;
    logic [CH_ID_WIDTH-1:0] pend_low;
    logic [CH_COUNT-1:0]    fl_use_asid;
    logic [CH_COUNT-1:0]    fl_use_vpn;
    logic [VPN_WIDTH-1:0]   fl_vpn  [CH_COUNT];
    logic [ASID_WIDTH-1:0]  fl_asid [CH_COUNT];
    fl_state_e              fl_state;
    fl_state_e              fl_state_nxt;
    logic [CH_ID_WIDTH-1:0] flush_sel;
    logic [CH_ID_WIDTH-1:0] flush_sel_nxt;
    logic [CH_COUNT-1:0]    flush_grant;
    logic [CH_COUNT-1:0]    flush_grant_nxt;

    assign eligible = locked ? '0 : ch_req_vld_i;

    always_comb begin
        int idx;
        arb_found = 1'b0;
        arb_idx   = '0;
        idx       = 0;
        if (ARB_MODE == 1) begin
            for (int k = 0; k < CH_COUNT; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= CH_COUNT) idx = idx - CH_COUNT;
                if (!arb_found && eligible[idx]) begin
                    arb_found = 1'b1;
                    arb_idx   = CH_ID_WIDTH'(idx);
                end
            end
        end else begin
            for (int k = CH_COUNT - 1; k >= 0; k--) begin
                if (eligible[k]) begin
                    arb_found = 1'b1;
                    arb_idx   = CH_ID_WIDTH'(k);
                end
            end
        end
    end

    // A held (locked) request is exempt from flush blocking so the channel contract can complete.
    assign winner        = locked ? lock_idx : arb_idx;
    assign req_any       = locked | arb_found;
    assign fifo_full     = (count == FULL_CNT);
    assign pend_any      = |pending;
    assign mmu_req_vld_o = req_any & ~fifo_full & ~(pend_any & ~locked);
    assign handshake     = mmu_req_vld_o & mmu_req_rdy_i;
    assign ch_req_rdy_o  = handshake ? (ONE_HOT0 << winner) : '0;

    assign mmu_req_trans_id_o    = mmu_req_vld_o ?
        ch_req_trans_id_i[int'(winner)*TRANS_ID_WIDTH +: TRANS_ID_WIDTH] : '0;
    assign mmu_req_asid_o        = mmu_req_vld_o ?
        ch_req_asid_i[int'(winner)*ASID_WIDTH +: ASID_WIDTH] : '0;
    assign mmu_req_vpn_o         = mmu_req_vld_o ?
        ch_req_vpn_i[int'(winner)*VPN_WIDTH +: VPN_WIDTH] : '0;
    assign mmu_req_access_type_o = mmu_req_vld_o ?
        ch_req_access_type_i[int'(winner)*2 +: 2] : '0;

    assign pop           = mmu_resp_vld_i & (count != '0);
    assign ch_resp_vld_o = pop ? (ONE_HOT0 << owner_q[rd_ptr]) : '0;
    assign resp_orphan_o = orphan;

    always_ff @(posedge clk) begin
        if (handshake) owner_q[wr_ptr] <= winner;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            locked   <= 1'b0;
            lock_idx <= '0;
            rr_ptr   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            orphan   <= 1'b0;
        end else begin
            if (handshake) begin
                locked <= 1'b0;
                wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
                if (ARB_MODE == 1) rr_ptr <= (winner == LAST_CH) ? '0 : winner + 1'b1;
            end else if (mmu_req_vld_o) begin
                locked   <= 1'b1;
                lock_idx <= winner;
            end
            if (pop) rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
            case ({handshake, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (mmu_resp_vld_i && (count == '0)) orphan <= 1'b1;
        end
    end

    // Flush capture: each channel keeps its own payload until its flush is issued.
    assign capture = ch_flush_vld_i & ~pending;

    always_ff @(posedge clk) begin
        for (int i = 0; i < CH_COUNT; i++) begin
            if (capture[i]) begin
                fl_use_asid[i] <= ch_flush_use_asid_i[i];
                fl_use_vpn[i]  <= ch_flush_use_vpn_i[i];
                fl_vpn[i]      <= ch_flush_vpn_i[i*VPN_WIDTH +: VPN_WIDTH];
                fl_asid[i]     <= ch_flush_asid_i[i*ASID_WIDTH +: ASID_WIDTH];
            end
        end
    end

    always_comb begin
        pend_low = '0;
        for (int k = CH_COUNT - 1; k >= 0; k--) begin
            if (pending[k]) pend_low = CH_ID_WIDTH'(k);
        end
    end

    always_comb begin
        fl_state_nxt    = fl_state;
        flush_sel_nxt   = flush_sel;
        flush_grant_nxt = '0;
        fl_clear        = '0;
        case (fl_state)
            FL_IDLE: begin
                if (pend_any && !locked) begin
                    fl_state_nxt  = FL_ISSUE;
                    flush_sel_nxt = pend_low;
                end
            end
            FL_ISSUE: begin
                if (mmu_flush_grant_i) begin
                    fl_state_nxt    = FL_IDLE;
                    fl_clear        = ONE_HOT0 << flush_sel;
                    flush_grant_nxt = ONE_HOT0 << flush_sel;
                end
            end
            default: fl_state_nxt = FL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fl_state    <= FL_IDLE;
            flush_sel   <= '0;
            flush_grant <= '0;
            pending     <= '0;
        end else begin
            fl_state    <= fl_state_nxt;
            flush_sel   <= flush_sel_nxt;
            flush_grant <= flush_grant_nxt;
            pending     <= (pending & ~fl_clear) | capture;
        end
    end

    assign ch_flush_grant_o     = flush_grant;
    assign mmu_flush_vld_o      = (fl_state == FL_ISSUE);
    assign mmu_flush_use_asid_o = mmu_flush_vld_o & fl_use_asid[flush_sel];
    assign mmu_flush_use_vpn_o  = mmu_flush_vld_o & fl_use_vpn[flush_sel];
    assign mmu_flush_vpn_o      = mmu_flush_vld_o ? fl_vpn[flush_sel] : '0;
    assign mmu_flush_asid_o     = mmu_flush_vld_o ? fl_asid[flush_sel] : '0;

endmodule

// File: tb/tb_rvh_mmu_req_arbiter.sv
// Directed bench: fixed-priority 2-channel instance (a_*) and round-robin
// 3-channel instance (b_*) sharing one clock and reset.
module tb_rvh_mmu_req_arbiter;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Instance a: CH_COUNT=2, fixed priority, OUTSTANDING=2
    logic [1:0]  a_req_vld, a_req_rdy, a_resp_vld, a_fl_vld, a_fl_ua, a_fl_uv, a_fl_gnt;
    logic [5:0]  a_trans;
    logic [31:0] a_asid, a_fl_asid;
    logic [53:0] a_vpn, a_fl_vpn;
    logic [3:0]  a_acc;
    logic        a_mreq_vld, a_mrdy, a_mresp, a_mfl_vld, a_mfl_ua, a_mfl_uv, a_mfl_gnt, a_orphan;
    logic [2:0]  a_mtrans;
    logic [15:0] a_masid, a_mfl_asid;
    logic [26:0] a_mvpn, a_mfl_vpn;
    logic [1:0]  a_macc;

    // Instance b: CH_COUNT=3, round robin, OUTSTANDING=4
    logic [2:0]  b_req_vld, b_req_rdy, b_resp_vld, b_fl_vld, b_fl_ua, b_fl_uv, b_fl_gnt;
    logic [8:0]  b_trans;
    logic [47:0] b_asid, b_fl_asid;
    logic [80:0] b_vpn, b_fl_vpn;
    logic [5:0]  b_acc;
    logic        b_mreq_vld, b_mrdy, b_mresp, b_mfl_vld, b_mfl_ua, b_mfl_uv, b_mfl_gnt, b_orphan;
    logic [2:0]  b_mtrans;
    logic [15:0] b_masid, b_mfl_asid;
    logic [26:0] b_mvpn, b_mfl_vpn;
    logic [1:0]  b_macc;

    rvh_mmu_req_arbiter #(.CH_COUNT(2), .ARB_MODE(0), .OUTSTANDING(2)) dut_a (
        .clk(clk), .rstn(rstn),
        .ch_req_vld_i(a_req_vld), .ch_req_trans_id_i(a_trans), .ch_req_asid_i(a_asid),
        .ch_req_vpn_i(a_vpn), .ch_req_access_type_i(a_acc), .ch_req_rdy_o(a_req_rdy),
        .ch_resp_vld_o(a_resp_vld),
        .mmu_req_vld_o(a_mreq_vld), .mmu_req_trans_id_o(a_mtrans), .mmu_req_asid_o(a_masid),
        .mmu_req_vpn_o(a_mvpn), .mmu_req_access_type_o(a_macc), .mmu_req_rdy_i(a_mrdy),
        .mmu_resp_vld_i(a_mresp),
        .ch_flush_vld_i(a_fl_vld), .ch_flush_use_asid_i(a_fl_ua), .ch_flush_use_vpn_i(a_fl_uv),
        .ch_flush_vpn_i(a_fl_vpn), .ch_flush_asid_i(a_fl_asid), .ch_flush_grant_o(a_fl_gnt),
        .mmu_flush_vld_o(a_mfl_vld), .mmu_flush_use_asid_o(a_mfl_ua),
        .mmu_flush_use_vpn_o(a_mfl_uv), .mmu_flush_vpn_o(a_mfl_vpn),
        .mmu_flush_asid_o(a_mfl_asid), .mmu_flush_grant_i(a_mfl_gnt),
        .resp_orphan_o(a_orphan)
    );

    rvh_mmu_req_arbiter #(.CH_COUNT(3), .ARB_MODE(1), .OUTSTANDING(4)) dut_b (
        .clk(clk), .rstn(rstn),
        .ch_req_vld_i(b_req_vld), .ch_req_trans_id_i(b_trans), .ch_req_asid_i(b_asid),
        .ch_req_vpn_i(b_vpn), .ch_req_access_type_i(b_acc), .ch_req_rdy_o(b_req_rdy),
        .ch_resp_vld_o(b_resp_vld),
        .mmu_req_vld_o(b_mreq_vld), .mmu_req_trans_id_o(b_mtrans), .mmu_req_asid_o(b_masid),
        .mmu_req_vpn_o(b_mvpn), .mmu_req_access_type_o(b_macc), .mmu_req_rdy_i(b_mrdy),
        .mmu_resp_vld_i(b_mresp),
        .ch_flush_vld_i(b_fl_vld), .ch_flush_use_asid_i(b_fl_ua), .ch_flush_use_vpn_i(b_fl_uv),
        .ch_flush_vpn_i(b_fl_vpn), .ch_flush_asid_i(b_fl_asid), .ch_flush_grant_o(b_fl_gnt),
        .mmu_flush_vld_o(b_mfl_vld), .mmu_flush_use_asid_o(b_mfl_ua),
        .mmu_flush_use_vpn_o(b_mfl_uv), .mmu_flush_vpn_o(b_mfl_vpn),
        .mmu_flush_asid_o(b_mfl_asid), .mmu_flush_grant_i(b_mfl_gnt),
        .resp_orphan_o(b_orphan)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        rstn = 1'b0;
        a_req_vld = '0; a_mrdy = 0; a_mresp = 0; a_fl_vld = '0; a_fl_ua = '0; a_fl_uv = '0;
        a_mfl_gnt = 0; a_fl_vpn = '0; a_fl_asid = '0;
        a_trans = {3'd2, 3'd1};
        a_asid  = {16'h00B1, 16'h00A0};
        a_vpn   = {27'h00000BB, 27'h00000AA};
        a_acc   = {2'd2, 2'd1};
        b_req_vld = '0; b_mrdy = 0; b_mresp = 0; b_fl_vld = '0; b_fl_ua = '0; b_fl_uv = '0;
        b_mfl_gnt = 0; b_fl_vpn = '0; b_fl_asid = '0;
        b_trans = {3'd6, 3'd5, 3'd4};
        b_asid  = {16'h0C2, 16'h0C1, 16'h0C0};
        b_vpn   = {27'h0D2, 27'h0D1, 27'h0D0};
        b_acc   = {2'd2, 2'd1, 2'd0};

        tick(); tick();
        chk("rst_mreq_vld", a_mreq_vld, 0);
        chk("rst_req_rdy", a_req_rdy, 0);
        chk("rst_mflush_vld", a_mfl_vld, 0);
        chk("rst_flush_gnt", a_fl_gnt, 0);
        chk("rst_orphan", a_orphan, 0);
        rstn = 1'b1;
        tick();

        // Fixed priority: channel 0 wins every cycle, channel 1 starves
        a_req_vld = 2'b11; a_mrdy = 1;
        for (int k = 0; k < 3; k++) begin
            a_mresp = (k > 0);
            settle();
            chk("fp_mreq_vld", a_mreq_vld, 1);
            chk("fp_req_rdy", a_req_rdy, 2'b01);
            chk("fp_tid", a_mtrans, 3'd1);
            chk("fp_resp_vld", a_resp_vld, (k > 0) ? 2'b01 : 2'b00);
            tick();
        end
        chk("fp_vpn", 0, 0 + (a_mvpn !== 27'h0AA));
        a_req_vld = 2'b00; a_mresp = 1;
        settle();
        chk("fp_drain_resp", a_resp_vld, 2'b01);
        chk("fp_idle_mreq", a_mreq_vld, 0);
        tick();
        a_mresp = 0;

        // Lock: channel 1 held under backpressure while channel 0 joins
        a_mrdy = 0; a_req_vld = 2'b10;
        settle();
        chk("lk_vld", a_mreq_vld, 1);
        chk("lk_tid1", a_mtrans, 3'd2);
        chk("lk_rdy_none", a_req_rdy, 2'b00);
        tick();
        a_req_vld = 2'b11;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("lk_hold_tid", a_mtrans, 3'd2);
            chk("lk_hold_asid", a_masid, 16'h00B1);
            tick();
        end
        a_mrdy = 1;
        settle();
        chk("lk_release_rdy", a_req_rdy, 2'b10);
        tick();
        a_req_vld = 2'b01;
        settle();
        chk("lk_next_rdy", a_req_rdy, 2'b01);
        chk("lk_next_tid", a_mtrans, 3'd1);
        tick();

        // Owner FIFO full (owners 1 then 0)
        a_req_vld = 2'b11;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("full_blocks", a_mreq_vld, 0);
            chk("full_rdy", a_req_rdy, 2'b00);
            tick();
        end
        a_mresp = 1;
        settle();
        chk("full_pop_blocks", a_mreq_vld, 0);
        chk("resp_owner1", a_resp_vld, 2'b10);
        tick();
        a_req_vld = 2'b00;
        settle();
        chk("resp_owner2", a_resp_vld, 2'b01);
        tick();
        settle();
        chk("orphan_no_resp", a_resp_vld, 2'b00);
        chk("orphan_not_yet", a_orphan, 0);
        tick();
        a_mresp = 0;
        settle();
        chk("orphan_set", a_orphan, 1);

        // Two same-cycle flushes, serialised with their own payloads
        a_fl_vld  = 2'b11;
        a_fl_ua   = 2'b01;
        a_fl_uv   = 2'b10;
        a_fl_asid = {16'h0099, 16'h0005};
        a_fl_vpn  = {27'h0000123, 27'h0000777};
        tick();
        a_fl_vld = 2'b00; a_req_vld = 2'b11;
        settle();
        chk("fl_block_req", a_mreq_vld, 0);
        chk("fl_not_issued", a_mfl_vld, 0);
        tick();
        settle();
        chk("fl0_vld", a_mfl_vld, 1);
        chk("fl0_use_asid", a_mfl_ua, 1);
        chk("fl0_use_vpn", a_mfl_uv, 0);
        chk("fl0_asid", a_mfl_asid, 16'h0005);
        chk("fl0_block_req", a_mreq_vld, 0);
        tick();
        a_mfl_gnt = 1;
        settle();
        chk("fl0_hold", a_mfl_vld, 1);
        chk("fl0_no_gnt_yet", a_fl_gnt, 2'b00);
        tick();
        a_mfl_gnt = 0;
        settle();
        chk("fl0_gnt", a_fl_gnt, 2'b01);
        chk("fl_gap_idle", a_mfl_vld, 0);
        chk("fl1_block_req", a_mreq_vld, 0);
        tick();
        a_mfl_gnt = 1;
        settle();
        chk("fl1_vld", a_mfl_vld, 1);
        chk("fl1_use_vpn", a_mfl_uv, 1);
        chk("fl1_use_asid", a_mfl_ua, 0);
        chk("fl1_vpn", a_mfl_vpn, 27'h0000123);
        chk("fl1_gnt_clear", a_fl_gnt, 2'b00);
        chk("fl1_block_req", a_mreq_vld, 0);
        tick();
        a_mfl_gnt = 0;
        settle();
        chk("fl1_gnt", a_fl_gnt, 2'b10);
        chk("post_fl_req", a_mreq_vld, 1);
        chk("post_fl_rdy", a_req_rdy, 2'b01);
        tick();
        tick();
        a_req_vld = 2'b00; a_fl_vld = 2'b10;
        tick();
        a_fl_vld = 2'b00;

        // Asynchronous reset with two outstanding and a flush pending
        #1 rstn = 1'b0;
        #1;
        chk("arst_orphan", a_orphan, 0);
        chk("arst_mflush", a_mfl_vld, 0);
        chk("arst_mreq", a_mreq_vld, 0);
        chk("arst_gnt", a_fl_gnt, 0);
        tick(); tick();
        rstn = 1'b1;
        tick();
        a_req_vld = 2'b01; a_mrdy = 0; a_mresp = 1;
        settle();
        chk("arst_no_fl_block", a_mreq_vld, 1);
        chk("arst_fifo_empty", a_resp_vld, 2'b00);
        tick();
        a_req_vld = 2'b00; a_mresp = 0;
        settle();
        chk("arst_orphan_set", a_orphan, 1);

        // Round robin over three channels
        tick();
        b_req_vld = 3'b111; b_mrdy = 1;
        for (int k = 0; k < 6; k++) begin
            b_mresp = (k > 0);
            settle();
            chk("rr_rdy", b_req_rdy, 3'b001 << (k % 3));
            chk("rr_tid", b_mtrans, 4 + (k % 3));
            chk("rr_resp", b_resp_vld, (k > 0) ? (3'b001 << ((k - 1) % 3)) : 3'b000);
            tick();
        end
        b_req_vld = 3'b000; b_mresp = 1;
        settle();
        chk("rr_drain", b_resp_vld, 3'b100);
        tick();
        b_mresp = 0; b_req_vld = 3'b110;
        settle();
        chk("rr_skip0", b_req_rdy, 3'b010);
        tick();
        b_req_vld = 3'b101;
        settle();
        chk("rr_ptr2", b_req_rdy, 3'b100);
        chk("rr_ptr2_vpn", b_mvpn, 27'h0D2);
        tick();
        b_req_vld = 3'b110;
        settle();
        chk("rr_wrap", b_req_rdy, 3'b010);
        tick();
        b_req_vld = 3'b000;
        settle();
        chk("rr_orphan", b_orphan, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
